// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage bus between the pipeline and the multiply/divide unit
interface mdu_ctrl_if;
    logic [3:0]  md_op_E;
    logic        start_E;
    logic [31:0] rs_val_E;
    logic [31:0] rt_val_E;
    logic        md_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out_E;

    // Pipeline side: issues ops and operands, observes status and HI/LO
    modport master (
        output md_op_E, start_E, rs_val_E, rt_val_E, md_D,
        input  busy, md_stall, hi, lo, md_out_E
    );

    // Unit side
    modport slave (
        input  md_op_E, start_E, rs_val_E, rt_val_E, md_D,
        output busy, md_stall, hi, lo, md_out_E
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit with busy sequencer and HI/LO ownership
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave md
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [31:0]    hi_q, lo_q;
    logic [31:0]    hi_n_q, lo_n_q;
    logic [31:0]    hi_n_d, lo_n_d;

    logic           launch;
    logic signed [63:0] prod_s;
    logic [63:0]    prod_u;
    logic [31:0]    a_mag, b_mag, q_mag, r_mag, divu_d;

    assign launch = md.start_E && (md.md_op_E >= OP_MULT) && (md.md_op_E <= OP_DIVU);

    // Result datapath; a zero divisor keeps the current HI/LO as the pending result
    always_comb begin
        prod_s = $signed({{32{md.rs_val_E[31]}}, md.rs_val_E})
               * $signed({{32{md.rt_val_E[31]}}, md.rt_val_E});
        prod_u = {32'd0, md.rs_val_E} * {32'd0, md.rt_val_E};
        // Signed divide on magnitudes; 0x80000000 as an unsigned magnitude is exact,
        // which makes the 0x80000000 / -1 overflow case fall out as lo=0x80000000, hi=0.
        a_mag  = md.rs_val_E[31] ? -md.rs_val_E : md.rs_val_E;
        b_mag  = md.rt_val_E[31] ? -md.rt_val_E : md.rt_val_E;
        if (b_mag == 32'd0) begin
            b_mag = 32'd1;
        end
        q_mag  = a_mag / b_mag;
        r_mag  = a_mag % b_mag;
        divu_d = (md.rt_val_E == 32'd0) ? 32'd1 : md.rt_val_E;
        hi_n_d = hi_q;
        lo_n_d = lo_q;
        case (md.md_op_E)
            OP_MULT:  {hi_n_d, lo_n_d} = prod_s;
            OP_MULTU: {hi_n_d, lo_n_d} = prod_u;
            OP_DIV: begin
                if (md.rt_val_E != 32'd0) begin
                    lo_n_d = (md.rs_val_E[31] ^ md.rt_val_E[31]) ? -q_mag : q_mag;
                    hi_n_d = md.rs_val_E[31] ? -r_mag : r_mag;
                end
            end
            OP_DIVU: begin
                if (md.rt_val_E != 32'd0) begin
                    lo_n_d = md.rs_val_E / divu_d;
                    hi_n_d = md.rs_val_E % divu_d;
                end
            end
            default: ;
        endcase
    end

    // Sequencer: launch captures the result, counter runs it out, commit on count 1
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_n_q  <= '0;
            lo_n_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        hi_n_q  <= hi_n_d;
                        lo_n_q  <= lo_n_d;
                        cnt_q   <= (md.md_op_E <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end else if (!md.start_E && md.md_op_E == OP_MTHI) begin
                        hi_q <= md.rs_val_E;
                    end else if (!md.start_E && md.md_op_E == OP_MTLO) begin
                        lo_q <= md.rs_val_E;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CNT_ONE) begin
                        hi_q    <= hi_n_q;
                        lo_q    <= lo_n_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read port and stall request
    always_comb begin
        case (md.md_op_E)
            OP_MFHI: md.md_out_E = hi_q;
            OP_MFLO: md.md_out_E = lo_q;
            default: md.md_out_E = 32'd0;
        endcase
        md.md_stall = md.md_D & (md.start_E | busy_q);
    end

    assign md.busy = busy_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed vector bench for mdu_ctrl
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.md_op_E  = 4'd0;
        bus.start_E  = 1'b0;
        bus.md_D     = 1'b0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        @(posedge clk); #1;
        bus.md_op_E  = op;
        bus.start_E  = 1'b0;
        bus.rs_val_E = val;
        @(posedge clk); #1;
        idle_bus();
    endtask

    // Launch one op with md_D high in the launch cycle, then count busy cycles
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int exp_cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        @(posedge clk); #1;
        bus.md_op_E  = op;
        bus.start_E  = 1'b1;
        bus.rs_val_E = rs;
        bus.rt_val_E = rt;
        bus.md_D     = 1'b1;
        @(negedge clk);
        check({tag, " stall_at_launch"}, {31'd0, bus.md_stall}, 32'd1);
        @(posedge clk); #1;
        idle_bus();
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            bus.md_D = (n == 1);
            @(negedge clk);
            if (n <= 2)
                check($sformatf("%s stall_busy_c%0d", tag, n), {31'd0, bus.md_stall},
                      (n == 1) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        bus.md_D = 1'b0;
        check({tag, " busy_cycles"}, n, exp_cycles);
        check({tag, " hi"}, bus.hi, exp_hi);
        check({tag, " lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'h00000005, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[3] = '{4'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[6] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001};
        vecs[7] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[8] = '{4'd4, 32'hFFFFFFFF, 32'h0000000A, 10, 32'h00000005, 32'h19999999};
        vecs[9] = '{4'd1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};

        idle_bus();
        bus.rs_val_E = 32'd0;
        bus.rt_val_E = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset md_out", bus.md_out_E, 32'd0);
        check("reset stall", {31'd0, bus.md_stall}, 32'd0);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].cycles, vecs[i].hi, vecs[i].lo);

        // mthi/mtlo, divide by zero leaves HI/LO, then reads
        move_to(4'd5, 32'h00001234);
        move_to(4'd6, 32'h00005678);
        check("mthi hi", bus.hi, 32'h00001234);
        check("mtlo lo", bus.lo, 32'h00005678);
        run_op("div0", 4'd3, 32'h00000009, 32'h00000000, 10, 32'h00001234, 32'h00005678);
        run_op("divu0", 4'd4, 32'h00000009, 32'h00000000, 10, 32'h00001234, 32'h00005678);
        bus.md_op_E = 4'd7;
        @(negedge clk);
        check("mfhi out", bus.md_out_E, 32'h00001234);
        bus.md_op_E = 4'd8;
        @(negedge clk);
        check("mflo out", bus.md_out_E, 32'h00005678);
        bus.md_op_E = 4'd9;
        @(negedge clk);
        check("op9 out", bus.md_out_E, 32'd0);

        // Op 1 without start has no effect
        @(posedge clk); #1;
        bus.md_op_E  = 4'd1;
        bus.start_E  = 1'b0;
        bus.rs_val_E = 32'h00000003;
        bus.rt_val_E = 32'h00000003;
        @(posedge clk); #1;
        idle_bus();
        check("nostart busy", {31'd0, bus.busy}, 32'd0);
        check("nostart lo", bus.lo, 32'h00005678);

        // Start and mthi while busy are ignored
        move_to(4'd5, 32'h0000AAAA);
        @(posedge clk); #1;
        bus.md_op_E  = 4'd1;
        bus.start_E  = 1'b1;
        bus.rs_val_E = 32'h00010000;
        bus.rt_val_E = 32'h00030000;
        @(posedge clk); #1;
        idle_bus();
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            if (n == 4)
                check("busy mthi ignored", bus.hi, 32'h0000AAAA);
            if (n == 2) begin
                bus.md_op_E  = 4'd3;
                bus.start_E  = 1'b1;
                bus.rs_val_E = 32'd100;
                bus.rt_val_E = 32'd7;
            end else if (n == 3) begin
                bus.md_op_E  = 4'd5;
                bus.start_E  = 1'b0;
                bus.rs_val_E = 32'h0000DEAD;
            end else begin
                idle_bus();
            end
            @(posedge clk); #1;
        end
        idle_bus();
        check("restart busy_cycles", n, 32'd5);
        check("restart hi", bus.hi, 32'h00000003);
        check("restart lo", bus.lo, 32'h00000000);

        // Reset on the 4th busy cycle of a divide aborts it
        move_to(4'd5, 32'h0000BEEF);
        @(posedge clk); #1;
        bus.md_op_E  = 4'd3;
        bus.start_E  = 1'b1;
        bus.rs_val_E = 32'd100;
        bus.rt_val_E = 32'd7;
        @(posedge clk); #1;
        idle_bus();
        n = 0;
        while (bus.busy === 1'b1 && n < 4) begin
            n++;
            if (n == 4)
                reset = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
                n++;
        end
        check("abort no late commit", n, 32'd0);
        run_op("post_reset", 4'd1, 32'hFFFFFFFD, 32'h00000005, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
